path_delay_tester: RTL and testbench
====================================

Name: path_delay_tester

Overview:
- Launch/capture controller placed directly upstream and downstream of one delay-chain path under test.
- Drives the path's input with a transition, then samples the path's output a programmable number of clock cycles later.
- Compares the sample with the expected settled value and counts late arrivals over a batch of trials.
- A golden (Trojan-free) path and a suspect path show different fail counts at a given capture delay; software sweeps captureDelay to locate each path's delay threshold.

Parameters:
- TRIAL_W, 16, width of numTrials and of the internal trial counter.
- CNT_W, 16, width of failCount. The count saturates.
- SETTLE_CYCLES, 8, idle cycles after each capture so the path fully settles before the next launch (minimum 1).
- PATH_INVERTS, 0, set to 1 if the path under test has odd inversion parity. Expected value = pathInput ^ PATH_INVERTS.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a batch. Sampled only in IDLE.
- numTrials  input  TRIAL_W  number of launch/capture trials in the batch. Latched on start.
- captureDelay  input  4  clock edges from the launch edge to the capture edge. Latched on start; value 0 is treated as 1.
- pathInput  output  1  registered launch signal driving the path input.
- pathResult  input  1  path output. Sampled raw by a single capture flop, with no synchronizer (the metastability window is the measurement).
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the batch completes.
- failCount  output  CNT_W  trials whose captured value differed from the expected value.
- lastSample  output  1  most recent captured pathResult, for debug.

Behaviour:
- Reset (asynchronous, at any time, including mid-batch):
  - State goes to IDLE.
  - pathInput, busy, done, failCount, lastSample, trial counter and wait counter all go to 0.
- States: IDLE, LAUNCH, WAIT, COMPARE, SETTLE, DONE.
- IDLE:
  - On start=1: latch numTrials and captureDelay (0 becomes 1), clear failCount, set busy.
  - If numTrials==0, go to DONE; otherwise go to LAUNCH.
  - start=0: stay in IDLE.
- LAUNCH (1 cycle): toggle pathInput, load waitCnt=captureDelay, go to WAIT. The clock edge leaving LAUNCH is the launch edge.
- WAIT:
  - Decrement waitCnt each cycle.
  - On the edge where waitCnt==1: captureReg <= pathResult and lastSample <= pathResult, then go to COMPARE.
  - The capture edge is therefore exactly captureDelay edges after the launch edge.
- COMPARE (1 cycle):
  - If captureReg != (pathInput ^ PATH_INVERTS), increment failCount, saturating at 2^CNT_W-1.
  - Increment trialCnt, load settleCnt=SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - Count down settleCnt.
  - At expiry, go to DONE if trialCnt==numTrials, else go to LAUNCH.
- DONE (1 cycle): done=1, busy=0, go to IDLE. failCount holds until the next start or reset.
- Transitions alternate every trial (rise, fall, rise, ...), so both edge polarities are measured. pathInput keeps its value across batches.
- Per-trial period is 2 + captureDelay + SETTLE_CYCLES cycles.
- start while busy is ignored; the latched parameters do not change mid-batch.
- Changes on numTrials or captureDelay during a batch have no effect.

Test Plan:
- Path model = 2-cycle delay, PATH_INVERTS=0, numTrials=8, captureDelay=3.
  - Expect failCount=0, done pulse exactly 8*(2+3+8)+1 cycles after busy rises, pathInput=0 at end (8 toggles).
- Same path model, captureDelay=1.
  - Expect failCount=8, lastSample equal to the pre-launch value.
- Inverting path model with PATH_INVERTS=1, captureDelay=4, numTrials=5.
  - Expect failCount=0 and pathInput=1 at end.
- numTrials=0.
  - Expect busy high 1 cycle, done pulse on the second cycle after start, failCount=0, pathInput unchanged.
- CNT_W=3, path output stuck at 0, numTrials=20.
  - Expect failCount saturates at 7; a start pulse issued mid-batch is ignored (still 20 trials).
- Assert rst_n low during WAIT of trial 3.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - A following start runs a clean batch, with failCount counted from 0.

Source files
------------

// File: rtl/path_delay_tester.sv
// Launch/capture controller for one delay path under test. It toggles the path input,
// samples the path output captureDelay edges later and counts late arrivals over a batch.
module path_delay_tester #(
  parameter int TRIAL_W       = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int PATH_INVERTS  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TRIAL_W-1:0] numTrials,
  input  logic [3:0]         captureDelay,
  output logic               pathInput,
  input  logic               pathResult,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   failCount,
  output logic               lastSample
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] COMPARE = 3'd3;
  localparam logic [2:0] SETTLE  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int   SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic INV   = (PATH_INVERTS != 0);

  logic [2:0]         state;
  logic [TRIAL_W-1:0] numTrialsReg;
  logic [TRIAL_W-1:0] trialCnt;
  logic [3:0]         delayReg;
  logic [3:0]         waitCnt;
  logic [SET_W-1:0]   settleCnt;
  logic               captureReg;
  logic               lateArrival;

  // pathInput has already toggled by COMPARE, so it is the value the path should show now.
  assign lateArrival = (captureReg != (pathInput ^ INV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      numTrialsReg <= '0;
      trialCnt     <= '0;
      delayReg     <= 4'd1;
      waitCnt      <= '0;
      settleCnt    <= '0;
      captureReg   <= 1'b0;
      pathInput    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      failCount    <= '0;
      lastSample   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            numTrialsReg <= numTrials;
            delayReg     <= (captureDelay == 4'd0) ? 4'd1 : captureDelay;
            failCount    <= '0;
            trialCnt     <= '0;
            busy         <= 1'b1;
            state        <= (numTrials == '0) ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          pathInput <= ~pathInput;
          waitCnt   <= delayReg;
          state     <= WAIT;
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          // Raw sample, no synchronizer: a marginal arrival is exactly what is being measured.
          if (waitCnt == 4'd1) begin
            captureReg <= pathResult;
            lastSample <= pathResult;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (lateArrival && (failCount != '1))
            failCount <= failCount + CNT_W'(1);
          trialCnt  <= trialCnt + TRIAL_W'(1);
          settleCnt <= SET_W'(SETTLE_CYCLES);
          state     <= SETTLE;
        end
        SETTLE: begin
          settleCnt <= settleCnt - SET_W'(1);
          if (settleCnt == SET_W'(1))
            state <= (trialCnt == numTrialsReg) ? DONE : LAUNCH;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_tester.sv
// Directed bench: unit 0 default params (2-cycle path or stuck-0), unit 1 inverting path,
// unit 2 narrow saturating counter with a stuck-0 path.
module tb_path_delay_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       startV = '0;
  logic [2:0][15:0] ntV = '0;
  logic [2:0][3:0]  cdV = '0;
  wire  [2:0]       pinV, busyV, doneV, lastV, resV;
  wire  [2:0][15:0] fcV;
  wire  [2:0]       fcC;
  logic             stuckA = 1'b0;
  logic [2:0]       d1 = '0, d2 = '0;

  int checks = 0;
  int errors = 0;

  // Path models: two-flop delay, optionally inverted or stuck low.
  always @(posedge clk) begin
    d1 <= pinV;
    d2 <= d1;
  end
  assign resV[0] = stuckA ? 1'b0 : d2[0];
  assign resV[1] = ~d2[1];
  assign resV[2] = 1'b0;
  assign fcV[2]  = {13'd0, fcC};

  path_delay_tester dutA (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .numTrials(ntV[0]), .captureDelay(cdV[0]),
    .pathInput(pinV[0]), .pathResult(resV[0]), .busy(busyV[0]), .done(doneV[0]),
    .failCount(fcV[0]), .lastSample(lastV[0]));

  path_delay_tester #(.PATH_INVERTS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .numTrials(ntV[1]), .captureDelay(cdV[1]),
    .pathInput(pinV[1]), .pathResult(resV[1]), .busy(busyV[1]), .done(doneV[1]),
    .failCount(fcV[1]), .lastSample(lastV[1]));

  path_delay_tester #(.CNT_W(3)) dutC (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .numTrials(ntV[2]), .captureDelay(cdV[2]),
    .pathInput(pinV[2]), .pathResult(resV[2]), .busy(busyV[2]), .done(doneV[2]),
    .failCount(fcC), .lastSample(lastV[2]));

  typedef struct {
    int unit; int n; int d; bit stuck;
    int expFail; bit expPin; bit chkLast; bit expLast; int expCyc;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one start and counts edges from busy rising until the done pulse.
  task automatic runBatch(input int u, input int n, input int d, input int maxCyc, output int cyc);
    @(negedge clk);
    ntV[u] = 16'(n);
    cdV[u] = 4'(d);
    startV[u] = 1'b1;
    @(posedge clk);
    #1;
    startV[u] = 1'b0;
    chk("busyRise", 32'(busyV[u]), 1);
    cyc = 0;
    while (!doneV[u] && cyc < maxCyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!doneV[u]) begin
      errors++;
      $display("FAIL timeout unit %0d: no done after %0d cycles", u, maxCyc);
    end
  endtask

  initial begin
    int cyc;
    //        unit n  d stuck fail pin chk last cyc
    vecs[0] = '{0, 8, 3, 0, 0, 0, 1, 0, 105};
    vecs[1] = '{0, 8, 1, 0, 8, 0, 1, 1, 89};
    vecs[2] = '{0, 8, 2, 0, 8, 0, 1, 1, 97};
    vecs[3] = '{0, 0, 3, 0, 0, 0, 0, 0, 1};
    vecs[4] = '{0, 2, 0, 0, 2, 0, 1, 1, 23};
    vecs[5] = '{0, 3, 4, 0, 0, 1, 1, 1, 43};
    vecs[6] = '{0, 3, 2, 0, 3, 0, 1, 1, 37};
    vecs[7] = '{0, 4, 5, 1, 2, 0, 1, 0, 61};
    vecs[8] = '{1, 5, 4, 0, 0, 1, 1, 0, 71};

    #1;
    for (int u = 0; u < 3; u++) begin
      chk("rstPin", 32'(pinV[u]), 0);
      chk("rstBusy", 32'(busyV[u]), 0);
      chk("rstFail", 32'(fcV[u]), 0);
    end
    chk("rstDone", 32'(doneV[0]), 0);
    chk("rstLast", 32'(lastV[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      stuckA = vecs[i].stuck;
      repeat (3) @(posedge clk);
      runBatch(vecs[i].unit, vecs[i].n, vecs[i].d, 400, cyc);
      chk($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].expCyc));
      chk($sformatf("v%0d busyEnd", i), 32'(busyV[vecs[i].unit]), 0);
      chk($sformatf("v%0d failCount", i), 32'(fcV[vecs[i].unit]), 32'(vecs[i].expFail));
      chk($sformatf("v%0d pathInput", i), 32'(pinV[vecs[i].unit]), 32'(vecs[i].expPin));
      if (vecs[i].chkLast)
        chk($sformatf("v%0d lastSample", i), 32'(lastV[vecs[i].unit]), 32'(vecs[i].expLast));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d donePulse", i), 32'(doneV[vecs[i].unit]), 0);
    end
    stuckA = 1'b0;

    // Saturation plus ignored start and parameter changes mid-batch.
    fork
      runBatch(2, 20, 1, 400, cyc);
      begin
        repeat (50) @(posedge clk);
        @(negedge clk);
        startV[2] = 1'b1;
        ntV[2] = 16'd2;
        cdV[2] = 4'd9;
        @(negedge clk);
        startV[2] = 1'b0;
      end
    join
    chk("sat latency", 32'(cyc), 221);
    chk("sat failCount", 32'(fcV[2]), 7);
    chk("sat pathInput", 32'(pinV[2]), 0);

    // Asynchronous reset in the WAIT state of trial 3.
    repeat (3) @(posedge clk);
    @(negedge clk);
    ntV[0] = 16'd8;
    cdV[0] = 4'd1;
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    chk("preRst failCount", 32'(fcV[0]), 2);
    chk("preRst pathInput", 32'(pinV[0]), 1);
    chk("preRst lastSample", 32'(lastV[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midRst pathInput", 32'(pinV[0]), 0);
    chk("midRst busy", 32'(busyV[0]), 0);
    chk("midRst done", 32'(doneV[0]), 0);
    chk("midRst failCount", 32'(fcV[0]), 0);
    chk("midRst lastSample", 32'(lastV[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    runBatch(0, 8, 3, 400, cyc);
    chk("postRst latency", 32'(cyc), 105);
    chk("postRst failCount", 32'(fcV[0]), 0);
    chk("postRst pathInput", 32'(pinV[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
